// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
//
// Control unit for the five-stage pipelined MIPS core. Decodes the ID-stage
// op code / funct, stages the resulting control bits through the ID/EX,
// EX/MEM and MEM/WB control registers, and resolves pipeline hazards:
//   - load-use stall        (one bubble into EX, PC and IF/ID held)
//   - multi-cycle multiply  (mul held in EX, bubbles into MEM, PC/IF/ID held)
//   - taken branch          (redirect + IF/ID flush + bubble into EX)
//   - jump in ID            (redirect + IF/ID flush)
// and produces the EX-stage operand forwarding selects.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   C_op_code, C_funct        ID-stage instruction fields
//   id_rs, id_rt, id_rd       ID-stage register fields
//   ex_zero                   ALU zero flag from EX
//   stall_if_id               hold PC and IF/ID
//   flush_if_id               zero IF/ID
//   pc_src                    take branch target
//   jump                      take jump target
//   ex_ALU_src, ex_reg_dest, ex_branch, ex_ALU_control   EX controls
//   mem_memWrite, mem_memtoReg, mem_reg_write, mem_dest  MEM controls
//   wb_reg_write, wb_memtoReg, wb_dest                   WB controls
//   forward_a, forward_b      EX operand select: 00 regfile, 10 EX/MEM,
//                             01 MEM/WB
//
// Multiply encoding: R-type with funct 6'b011000.
// ---------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            C_op_code,
    input  logic [5:0]            C_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  pc_src,
    output logic                  jump,
    output logic                  ex_ALU_src,
    output logic                  ex_reg_dest,
    output logic                  ex_branch,
    output logic [2:0]            ex_ALU_control,
    output logic                  mem_memWrite,
    output logic                  mem_memtoReg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_reg_write,
    output logic                  wb_memtoReg,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_MUL   = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_OTHER = 3'b111;

    // Counter load value: the mul spends MUL_LATENCY cycles in EX, the first
    // of which is the cycle it arrives, so MUL_LATENCY-1 extra hold cycles.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    // ---------------- ID decode ----------------
    logic                  w_id_rtype, w_id_sw, w_id_beq, w_id_j, w_id_mul;
    logic                  w_id_reg_write, w_id_memtoReg, w_id_memWrite;
    logic                  w_id_branch, w_id_ALU_src, w_id_reg_dest;
    logic [2:0]            w_id_alu_ctrl;
    logic [REG_ADDR_W-1:0] w_id_dest;

    always_comb begin
        w_id_rtype     = 1'b0;
        w_id_sw        = 1'b0;
        w_id_beq       = 1'b0;
        w_id_j         = 1'b0;
        w_id_mul       = 1'b0;
        w_id_reg_write = 1'b0;
        w_id_memtoReg  = 1'b0;
        w_id_memWrite  = 1'b0;
        w_id_branch    = 1'b0;
        w_id_ALU_src   = 1'b0;
        w_id_reg_dest  = 1'b0;
        w_id_alu_ctrl  = 3'b000;
        case (C_op_code)
            OP_LW: begin
                w_id_memtoReg  = 1'b1;
                w_id_ALU_src   = 1'b1;
                w_id_reg_write = 1'b1;
                w_id_alu_ctrl  = ALU_ADD;
            end
            OP_SW: begin
                w_id_sw       = 1'b1;
                w_id_memtoReg = 1'b1;
                w_id_ALU_src  = 1'b1;
                w_id_memWrite = 1'b1;
                w_id_alu_ctrl = ALU_ADD;
            end
            OP_ADDI: begin
                w_id_ALU_src   = 1'b1;
                w_id_reg_write = 1'b1;
                w_id_alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                w_id_beq      = 1'b1;
                w_id_branch   = 1'b1;
                w_id_alu_ctrl = ALU_SUB;
            end
            OP_J: begin
                w_id_j = 1'b1;
            end
            OP_RTYPE: begin
                w_id_rtype     = 1'b1;
                w_id_reg_write = 1'b1;
                w_id_reg_dest  = 1'b1;
                case (C_funct)
                    FN_ADD:  w_id_alu_ctrl = ALU_ADD;
                    FN_SUB:  w_id_alu_ctrl = ALU_SUB;
                    FN_SLT:  w_id_alu_ctrl = ALU_SLT;
                    FN_MUL: begin
                        w_id_alu_ctrl = ALU_MUL;
                        w_id_mul      = 1'b1;
                    end
                    FN_AND:  w_id_alu_ctrl = ALU_AND;
                    FN_OR:   w_id_alu_ctrl = ALU_OR;
                    default: w_id_alu_ctrl = ALU_OTHER;
                endcase
            end
            default: ;
        endcase
    end

    assign w_id_dest = w_id_reg_dest ? id_rd : id_rt;

    // ---------------- Pipeline registers ----------------
    logic                  r_ex_reg_write, r_ex_memtoReg, r_ex_memWrite;
    logic                  r_ex_branch, r_ex_ALU_src, r_ex_reg_dest;
    logic [2:0]            r_ex_alu_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_dest, r_ex_rs, r_ex_rt;
    logic                  r_mem_memWrite, r_mem_memtoReg, r_mem_reg_write;
    logic [REG_ADDR_W-1:0] r_mem_dest;
    logic                  r_wb_reg_write, r_wb_memtoReg;
    logic [REG_ADDR_W-1:0] r_wb_dest;
    logic [3:0]            r_mul_cnt;

    // ---------------- Hazard detection ----------------
    logic w_ex_is_lw, w_pc_src, w_mul_stall, w_lu_hazard, w_stall;
    logic w_jump, w_load_decode;

    // Only lw sets memtoReg together with reg_write (sw sets memtoReg alone).
    assign w_ex_is_lw  = r_ex_memtoReg & r_ex_reg_write;
    assign w_pc_src    = r_ex_branch & ex_zero;
    assign w_mul_stall = (r_mul_cnt != 4'd0);
    // rt is only a source for R-type, sw and beq; for lw/addi it is the dest.
    assign w_lu_hazard = w_ex_is_lw && (r_ex_dest != '0) &&
                         ((r_ex_dest == id_rs) ||
                          ((r_ex_dest == id_rt) && (w_id_rtype || w_id_sw || w_id_beq)));
    // A taken branch flushes the younger instruction, so stalling it is moot.
    assign w_stall       = !w_pc_src && (w_mul_stall || w_lu_hazard);
    assign w_jump        = !rst && w_id_j && !w_stall && !w_pc_src;
    assign w_load_decode = !w_pc_src && !w_mul_stall && !w_lu_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_reg_write  <= 1'b0;
            r_ex_memtoReg   <= 1'b0;
            r_ex_memWrite   <= 1'b0;
            r_ex_branch     <= 1'b0;
            r_ex_ALU_src    <= 1'b0;
            r_ex_reg_dest   <= 1'b0;
            r_ex_alu_ctrl   <= ALU_ADD;
            r_ex_dest       <= '0;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_mem_memWrite  <= 1'b0;
            r_mem_memtoReg  <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_dest      <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_memtoReg   <= 1'b0;
            r_wb_dest       <= '0;
            r_mul_cnt       <= 4'd0;
        end else begin
            // ID/EX: branch flush and load-use insert a bubble; a busy mul
            // keeps itself in EX.
            if (w_load_decode) begin
                r_ex_reg_write <= w_id_reg_write;
                r_ex_memtoReg  <= w_id_memtoReg;
                r_ex_memWrite  <= w_id_memWrite;
                r_ex_branch    <= w_id_branch;
                r_ex_ALU_src   <= w_id_ALU_src;
                r_ex_reg_dest  <= w_id_reg_dest;
                r_ex_alu_ctrl  <= w_id_alu_ctrl;
                r_ex_dest      <= w_id_dest;
                r_ex_rs        <= id_rs;
                r_ex_rt        <= id_rt;
            end else if (w_pc_src || !w_mul_stall) begin
                r_ex_reg_write <= 1'b0;
                r_ex_memtoReg  <= 1'b0;
                r_ex_memWrite  <= 1'b0;
                r_ex_branch    <= 1'b0;
                r_ex_ALU_src   <= 1'b0;
                r_ex_reg_dest  <= 1'b0;
                r_ex_alu_ctrl  <= ALU_ADD;
                r_ex_dest      <= '0;
                r_ex_rs        <= '0;
                r_ex_rt        <= '0;
            end

            // EX/MEM: bubble while the mul is still occupying EX.
            if (w_mul_stall && !w_pc_src) begin
                r_mem_memWrite  <= 1'b0;
                r_mem_memtoReg  <= 1'b0;
                r_mem_reg_write <= 1'b0;
                r_mem_dest      <= '0;
            end else begin
                r_mem_memWrite  <= r_ex_memWrite;
                r_mem_memtoReg  <= r_ex_memtoReg;
                r_mem_reg_write <= r_ex_reg_write;
                r_mem_dest      <= r_ex_dest;
            end

            // MEM/WB always advances.
            r_wb_reg_write <= r_mem_reg_write;
            r_wb_memtoReg  <= r_mem_memtoReg;
            r_wb_dest      <= r_mem_dest;

            // Mul occupancy counter.
            if (w_mul_stall)
                r_mul_cnt <= r_mul_cnt - 4'd1;
            else if (w_load_decode && w_id_mul)
                r_mul_cnt <= MUL_LOAD;
        end
    end

    // ---------------- Forwarding ----------------
    logic [1:0] w_fwd_a, w_fwd_b;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs))
            w_fwd_a = 2'b10;
        else if (r_wb_reg_write && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs))
            w_fwd_a = 2'b01;
        if (r_mem_reg_write && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt))
            w_fwd_b = 2'b10;
        else if (r_wb_reg_write && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt))
            w_fwd_b = 2'b01;
    end

    // ---------------- Outputs ----------------
    assign stall_if_id    = w_stall;
    assign pc_src         = w_pc_src;
    assign jump           = w_jump;
    assign flush_if_id    = w_pc_src | w_jump;
    assign ex_ALU_src     = r_ex_ALU_src;
    assign ex_reg_dest    = r_ex_reg_dest;
    assign ex_branch      = r_ex_branch;
    assign ex_ALU_control = r_ex_alu_ctrl;
    assign mem_memWrite   = r_mem_memWrite;
    assign mem_memtoReg   = r_mem_memtoReg;
    assign mem_reg_write  = r_mem_reg_write;
    assign mem_dest       = r_mem_dest;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_memtoReg    = r_wb_memtoReg;
    assign wb_dest        = r_wb_dest;
    assign forward_a      = w_fwd_a;
    assign forward_b      = w_fwd_b;

endmodule
